// File: rtl/alu_pkg.sv
// Shared ALU definitions: operand width, divider FSM encoding and adder mode constants.
package alu_pkg;
  localparam int ALU_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;
endpackage

// File: rtl/adder_16bit.sv
// 16-bit add/subtract unit; mode=1 inverts b so that cin=1 gives a-b with cout=1 meaning no borrow.
module adder_16bit
  import alu_pkg::*;
(
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        mode,
  input  logic        cin,
  output logic [15:0] s,
  output logic        cout
);
  logic [15:0] b_x;

  assign b_x       = (mode == MODE_SUB) ? ~b : b;
  assign {cout, s} = {1'b0, a} + {1'b0, b_x} + {16'd0, cin};
endmodule

// File: rtl/alu_seq_divider.sv
// Multi-cycle unsigned restoring divider: one quotient bit per cycle, trial subtract done by
// the shared adder_16bit.
module alu_seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_W,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_e       state_q;
  logic [WIDTH-1:0] r_q, q_q, d_q;
  logic [WIDTH-1:0] r_d, q_d;
  logic [CNT_W-1:0] cnt_q;
  logic             busy_q, done_q, dz_q;
  logic [WIDTH-1:0] quot_q, rem_q;

  logic [WIDTH-1:0] sh, add_a, add_b, add_s;
  logic             hb, add_cout, take;

  // Shift the next dividend bit into the partial remainder; hb is the bit shifted out the top.
  assign sh = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
  assign hb = r_q[WIDTH-1];

  assign add_a = (state_q == RUN) ? sh  : '0;
  assign add_b = (state_q == RUN) ? d_q : '0;

  adder_16bit u_adder (
    .a    (add_a),
    .b    (add_b),
    .mode (MODE_SUB),
    .cin  (1'b1),
    .s    (add_s),
    .cout (add_cout)
  );

  // With hb set the shifted remainder exceeds 2^WIDTH > D, so the subtract must succeed.
  assign take = add_cout | hb;
  assign r_d  = take ? add_s : sh;
  assign q_d  = {q_q[WIDTH-2:0], take};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      quot_q  <= '0;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            busy_q <= 1'b1;
            if (divisor != '0) begin
              q_q     <= dividend;
              d_q     <= divisor;
              r_q     <= '0;
              cnt_q   <= '0;
              dz_q    <= 1'b0;
              state_q <= RUN;
            end else begin
              quot_q  <= '1;
              rem_q   <= dividend;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end
        RUN: begin
          r_q   <= r_d;
          q_q   <= q_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Results take the final iteration's values directly, saving a cycle.
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            quot_q  <= q_d;
            rem_q   <= r_d;
            done_q  <= 1'b1;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dz_q;
endmodule

// File: tb/tb_alu_seq_divider.sv
// Randomized self-checking bench for alu_seq_divider against a / and % reference model.
module tb_alu_seq_divider;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] dividend, divisor;
  logic        busy, done, div_by_zero;
  logic [15:0] quotient, remainder;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_seq_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues one operation and checks latency, results and the busy/done handshake.
  // repulse_at >= 0 re-asserts start with other operands that many edges into the run.
  task automatic run_op(input logic [15:0] dd, input logic [15:0] dv, input int repulse_at,
                        input string tag);
    int          lat;
    int          wt;
    logic        busy_ok;
    logic [15:0] eq, er;
    logic        edz;
    int          elat;
    wt = 0;
    while (busy && wt < 40) begin
      @(posedge clk); #1; wt++;
    end
    if (busy) chk({tag, " idle_wait"}, 32'(busy), 32'd0);
    if (dv == 16'd0) begin
      eq = 16'hFFFF; er = dd; edz = 1'b1; elat = 0;
    end else begin
      eq = dd / dv; er = dd % dv; edz = 1'b0; elat = 16;
    end
    dividend = dd; divisor = dv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; dividend = 16'($urandom); divisor = 16'($urandom);
    lat = 0; busy_ok = 1'b1;
    while (!done && lat < 40) begin
      if (!busy) busy_ok = 1'b0;
      if (lat == repulse_at) begin
        start = 1'b1; dividend = 16'd7777; divisor = 16'd3;
      end
      @(posedge clk); #1;
      start = 1'b0;
      lat++;
    end
    chk({tag, " latency"}, 32'(lat), 32'(elat));
    chk({tag, " quotient"}, 32'(quotient), 32'(eq));
    chk({tag, " remainder"}, 32'(remainder), 32'(er));
    chk({tag, " div_by_zero"}, 32'(div_by_zero), 32'(edz));
    chk({tag, " busy_held"}, 32'(busy_ok & busy), 32'd1);
    @(posedge clk); #1;
    chk({tag, " done_pulse"}, {31'd0, done}, 32'd0);
    chk({tag, " busy_release"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [15:0] dd, dv;
    int          sel;
    int          seen_done;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset q", 32'(quotient), 32'd0);
    chk("reset r", 32'(remainder), 32'd0);
    chk("reset dz", {31'd0, div_by_zero}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run_op(16'd100, 16'd7, -1, "100/7");
    run_op(16'hFFFF, 16'h8001, -1, "ffff/8001");
    run_op(16'hFFFF, 16'd1, -1, "ffff/1");
    run_op(16'd5, 16'd0, -1, "5/0");
    run_op(16'd9, 16'd3, -1, "9/3");
    run_op(16'd3, 16'h1234, -1, "3/1234");
    run_op(16'd200, 16'd10, 5, "200/10 repulse");

    // Abort a run with reset and confirm nothing completes afterwards.
    dividend = 16'd1000; divisor = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort busy", {31'd0, busy}, 32'd0);
    chk("abort done", {31'd0, done}, 32'd0);
    chk("abort q", 32'(quotient), 32'd0);
    chk("abort r", 32'(remainder), 32'd0);
    chk("abort dz", {31'd0, div_by_zero}, 32'd0);
    seen_done = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (done || busy) seen_done++;
    end
    chk("abort no_done", 32'(seen_done), 32'd0);
    run_op(16'd50, 16'd6, -1, "50/6");

    for (int i = 0; i < 2000; i++) begin
      dd  = 16'($urandom);
      sel = int'($urandom_range(0, 9));
      case (sel)
        0:       dv = 16'd0;
        1:       dv = 16'd1;
        2:       dv = 16'($urandom_range(1, 255));
        3:       dv = dd;
        4:       dv = 16'h8000 | 16'($urandom);
        default: dv = 16'($urandom);
      endcase
      run_op(dd, dv, -1, $sformatf("rnd%0d %0h/%0h", i, dd, dv));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
